// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: owns the architectural PC, fetches one instruction at a time,
// offers decoded fields to the EXU and closes the loop on its next-PC commit.
module ysyx_22050612_ifu #(
  parameter int                XLEN     = 64,
  parameter logic [XLEN-1:0]   RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [9:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm_I,
  output logic [XLEN-1:0] pc,
  input  logic            dnpc_valid,
  input  logic [XLEN-1:0] dnpc,
  output logic            halted,
  output logic            fault,
  output logic [63:0]     instret
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_EXEC  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic [63:0]     r_instret;
  logic            r_halted;
  logic            r_fault;
  logic            r_req_valid;
  logic            r_inst_valid;

  logic            w_commit;
  logic            w_dnpc_aligned;

  assign w_commit       = ((r_state == S_ISSUE) && inst_ready && dnpc_valid) ||
                          ((r_state == S_EXEC) && dnpc_valid);
  assign w_dnpc_aligned = (dnpc[1:0] == 2'b00);

  // Fetch FSM; handshake valids are set on state entry so they stay pure registers.
  // A request is only raised when the PC entering REQ is word-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= NOP;
      r_instret    <= 64'd0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
    end else begin
      if (w_commit) begin
        r_pc      <= dnpc;
        r_instret <= r_instret + 64'd1;
      end
      case (r_state)
        S_IDLE: begin
          r_state     <= S_REQ;
          r_req_valid <= (r_pc[1:0] == 2'b00);
        end
        S_REQ: begin
          if (r_pc[1:0] != 2'b00) begin
            r_state     <= S_HALT;
            r_fault     <= 1'b1;
            r_req_valid <= 1'b0;
          end else if (imem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            r_inst <= imem_resp_data;
            if (imem_resp_data == EBREAK) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state      <= S_ISSUE;
              r_inst_valid <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (inst_ready) begin
            r_inst_valid <= 1'b0;
            if (dnpc_valid) begin
              r_state     <= S_REQ;
              r_req_valid <= w_dnpc_aligned;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (dnpc_valid) begin
            r_state     <= S_REQ;
            r_req_valid <= w_dnpc_aligned;
          end
        end
        S_HALT: begin
          r_req_valid  <= 1'b0;
          r_inst_valid <= 1'b0;
        end
        default: begin
          r_state      <= S_HALT;
          r_req_valid  <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_addr      = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign pc             = r_pc;
  assign halted         = r_halted;
  assign fault          = r_fault;
  assign instret        = r_instret;

  assign opcode = {r_inst[14:12], r_inst[6:0]};
  assign rd     = r_inst[11:7];
  assign rs1    = r_inst[19:15];
  assign rs2    = r_inst[24:20];
  assign imm_I  = {{(XLEN-12){r_inst[31]}}, r_inst[31:20]};

endmodule
